instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit_if.sv | 35 +++
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: imem read port, redirect inputs, decode outputs.
// master = fetch unit; slave = environment (imem + decode + redirect source).
interface instr_fetch_unit_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 20
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               jump_en;
  logic [PC_W-1:0]    jump_address;
  logic               branch_en;
  logic [PC_W-1:0]    branch_pc;
  logic [7:0]         branch_offset;
  logic [INSTR_W-1:0] instruction;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;

  modport master (
    output imem_req, imem_addr,
    output instruction, instr_pc, instr_valid,
    input  imem_rdata, stall,
    input  jump_en, jump_address,
    input  branch_en, branch_pc, branch_offset
  );

  modport slave (
    input  imem_req, imem_addr,
    input  instruction, instr_pc, instr_valid,
    output imem_rdata, stall,
    output jump_en, jump_address,
    output branch_en, branch_pc, branch_offset
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: 8-bit PC, 1-cycle sync imem, 1-entry skid, jump/branch redirect.
// Ports: clk, rst_n (async active-low), bus (instr_fetch_unit_if.master).
module instr_fetch_unit #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 20,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } slot_t;

  state_t          state;
  state_t          state_nx;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] inflight_pc;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] target;
  logic            inflight;
  logic            skid_valid;
  logic            valid;
  logic            redirect;
  logic            req;
  logic            accept;
  slot_t           out_q;
  slot_t           skid_q;
  slot_t           fill;

  assign redirect  = bus.jump_en | bus.branch_en;
  assign br_off    = PC_W'($signed(bus.branch_offset));
  assign br_target = bus.branch_pc + PC_W'(1) + br_off;
  // branch is the older instruction, so it wins over jump
  assign target    = bus.branch_en ? br_target
                                   : bus.jump_address;

  assign accept = ~valid | ~bus.stall;
  assign req    = (state != BOOT) & ~redirect
                & ~(valid & bus.stall);
  assign fill   = '{instr: bus.imem_rdata, pc: inflight_pc};

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc;
  assign bus.instruction = out_q.instr;
  assign bus.instr_pc    = out_q.pc;
  assign bus.instr_valid = valid;

  always_comb begin
    state_nx = state;
    unique case (state)
      BOOT: state_nx = RUN;
      RUN: begin
        if (!redirect && valid && bus.stall)
          state_nx = HOLD;
      end
      HOLD: begin
        if (redirect || !bus.stall)
          state_nx = RUN;
      end
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state    <= state_nx;
      inflight <= req;
      if (redirect) begin
        pc <= target;
      end else if (req) begin
        pc          <= pc + PC_W'(1);
        inflight_pc <= pc;
      end
    end
  end

  // Skid drains ahead of the returning word, keeping program order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      out_q      <= '0;
      skid_valid <= 1'b0;
      skid_q     <= '0;
    end else if (redirect) begin
      valid      <= 1'b0;
      skid_valid <= 1'b0;
    end else if (accept && skid_valid) begin
      out_q      <= skid_q;
      valid      <= 1'b1;
      skid_valid <= inflight;
      if (inflight)
        skid_q <= fill;
    end else if (accept && inflight) begin
      out_q <= fill;
      valid <= 1'b1;
    end else if (accept) begin
      valid <= 1'b0;
    end else if (inflight) begin
      skid_q     <= fill;
      skid_valid <= 1'b1;
    end
  end

endmodule
